// File: rtl/mem_io_responder.sv
// mem_io_responder
//   Far-end responder for the CPU's byte-wide memory bus. Serves every
//   request with a 2^RAM_ADDR_WIDTH byte RAM, a UART tx FIFO, an rx stream
//   port, a free-running cycle counter with a readable snapshot, and a
//   sticky program-stop flag. IO space is cpu_a[17:16] == 2'b11.
//
// Ports
//   clk_in, rst_in        clock, asynchronous active-low reset
//   cpu_a/cpu_wdata/cpu_wr  CPU request (present every cycle)
//   cpu_rdata             registered read data, valid the cycle after accept
//   rdy_out               combinational accept; low stalls the CPU
//   tx_data/tx_valid/tx_ready  tx FIFO head, valid/ready handshake
//   rx_data/rx_valid/rx_ready  rx byte stream; rx_ready marks consumption
//   halted                sticky program-stop flag
module mem_io_responder #(
   parameter int RAM_ADDR_WIDTH = 17,
   parameter int TX_FIFO_DEPTH  = 8
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] cpu_a,
   input  logic [7:0]  cpu_wdata,
   input  logic        cpu_wr,
   output logic [7:0]  cpu_rdata,
   output logic        rdy_out,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        halted
);

   localparam int PTR_W = $clog2(TX_FIFO_DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(TX_FIFO_DEPTH);

   localparam logic [17:0] IO_DATA  = 18'h30000;
   localparam logic [17:0] IO_CLK   = 18'h30004;
   localparam logic [17:0] IO_SNAP0 = 18'h30005;
   localparam logic [17:0] IO_SNAP1 = 18'h30006;
   localparam logic [17:0] IO_SNAP2 = 18'h30007;

   // Which register currently feeds cpu_rdata; NONE after reset forces 0x00.
   typedef enum logic [1:0] {SRC_NONE, SRC_RAM, SRC_IO} rd_src_t;

   logic [17:0]             addr;
   logic                    io_sel;
   logic                    tx_wr_req;
   logic                    rx_rd_req;
   logic                    fifo_full;
   logic                    push;
   logic                    pop;
   logic [7:0]              push_data;
   logic [7:0]              io_rd_val;
   logic                    unused_addr_bits;

   logic [7:0]              ram [0:(1<<RAM_ADDR_WIDTH)-1];
   logic [7:0]              ram_q;
   logic [7:0]              io_rdata;
   rd_src_t                 rd_src;

   logic [7:0]              tx_mem [0:TX_FIFO_DEPTH-1];
   logic [PTR_W-1:0]        wr_ptr;
   logic [PTR_W-1:0]        rd_ptr;
   logic [PTR_W:0]          tx_count;

   logic [31:0]             counter;
   logic [23:0]             snapshot;

   assign addr             = cpu_a[17:0];
   assign unused_addr_bits = ^cpu_a[31:18];
   assign io_sel           = (addr[17:16] == 2'b11);

   // Both tx-data and halt writes push a byte, so both stall on a full FIFO,
   // even when the data write carries 0x00 and would not push.
   assign tx_wr_req = io_sel && cpu_wr && ((addr == IO_DATA) || (addr == IO_CLK));
   assign rx_rd_req = io_sel && !cpu_wr && (addr == IO_DATA);
   assign fifo_full = (tx_count == FULL_CNT);

   assign rdy_out  = !(tx_wr_req && fifo_full) && !(rx_rd_req && !rx_valid);
   assign rx_ready = rx_rd_req && rx_valid;

   assign push      = rdy_out && io_sel && cpu_wr &&
                      (((addr == IO_DATA) && (cpu_wdata != 8'h00)) || (addr == IO_CLK));
   assign push_data = (addr == IO_CLK) ? 8'h00 : cpu_wdata;
   assign pop       = tx_valid && tx_ready;

   assign tx_valid = (tx_count != '0);
   assign tx_data  = tx_mem[rd_ptr];

   always_comb begin
      io_rd_val = 8'h00;
      case (addr)
         IO_DATA:  io_rd_val = rx_data;
         IO_CLK:   io_rd_val = counter[7:0];
         IO_SNAP0: io_rd_val = snapshot[7:0];
         IO_SNAP1: io_rd_val = snapshot[15:8];
         IO_SNAP2: io_rd_val = snapshot[23:16];
         default:  io_rd_val = 8'h00;
      endcase
   end

   always_comb begin
      cpu_rdata = 8'h00;
      case (rd_src)
         SRC_RAM: cpu_rdata = ram_q;
         SRC_IO:  cpu_rdata = io_rdata;
         default: cpu_rdata = 8'h00;
      endcase
   end

   // RAM and FIFO storage carry no reset so they map onto block memory.
   always_ff @(posedge clk_in) begin
      if (rdy_out && !io_sel) begin
         if (cpu_wr) ram[cpu_a[RAM_ADDR_WIDTH-1:0]] <= cpu_wdata;
         else        ram_q <= ram[cpu_a[RAM_ADDR_WIDTH-1:0]];
      end
   end

   always_ff @(posedge clk_in) begin
      if (push) tx_mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         rd_src   <= SRC_NONE;
         io_rdata <= 8'h00;
         halted   <= 1'b0;
         counter  <= 32'd0;
         snapshot <= 24'd0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         tx_count <= '0;
      end else begin
         if (rdy_out && !cpu_wr) begin
            rd_src <= io_sel ? SRC_IO : SRC_RAM;
            if (io_sel) io_rdata <= io_rd_val;
            if (io_sel && (addr == IO_CLK)) snapshot <= counter[31:8];
         end

         if (!halted) counter <= counter + 32'd1;
         if (rdy_out && io_sel && cpu_wr && (addr == IO_CLK)) halted <= 1'b1;

         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   tx_count <= tx_count + 1'b1;
            2'b01:   tx_count <= tx_count - 1'b1;
            default: tx_count <= tx_count;
         endcase
      end
   end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
Memory/IO responder on the far end of the CPU's byte-wide memory bus. It sits in the top-level next to the CPU core and serves the core's address/data/write strobes with:
- a 128 KB byte RAM,
- a UART-facing tx FIFO and rx stream port,
- a free-running clock counter and a program-stop flag.

It drives the CPU's read-data bus and ready input, so the core stalls on IO backpressure.

Parameters:
RAM_ADDR_WIDTH, 17, byte-address width of RAM (2^17 = 128 KB).
TX_FIFO_DEPTH, 8, tx FIFO entries; power of 2, at least 2.

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset; asynchronous, active-low
cpu_a  input  32  CPU address bus; bits 17:0 decoded
cpu_wdata  input  8  CPU write data (CPU's data output bus)
cpu_wr  input  1  1 = write, 0 = read; a request is present every cycle
cpu_rdata  output  8  read data to the CPU's data input bus
rdy_out  output  1  to CPU ready input; low = request not accepted, CPU holds
tx_data  output  8  tx FIFO head byte
tx_valid  output  1  tx FIFO non-empty
tx_ready  input  1  UART tx consumes head when tx_valid && tx_ready
rx_data  input  8  UART rx byte
rx_valid  input  1  rx byte available
rx_ready  output  1  pulses for one cycle when the rx byte is consumed
halted  output  1  program-stop flag

Behaviour:
Reset (rst_in low, asynchronous):
- cpu_rdata = 0x00, halted = 0, tx FIFO empty (tx_valid = 0), cycle counter = 0, snapshot = 0.
- RAM contents are not reset.

Address decode:
- IO when cpu_a[17:16] == 2'b11.
- Otherwise RAM at cpu_a[RAM_ADDR_WIDTH-1:0]; cpu_a[31:18] ignored.

rdy_out is combinational and goes low only in these two cases:
- (a) IO write to 0x30000 or 0x30004 while the tx FIFO is full.
- (b) IO read of 0x30000 while rx_valid = 0.
- Otherwise it is high.
- The CPU must not make cpu_a or cpu_wr depend combinationally on rdy_out.

Acceptance and latency:
- A request is accepted on a rising edge where rdy_out = 1.
- Accepted write: takes effect at that edge (1-cycle write).
- Accepted read: result is registered into cpu_rdata at that edge, valid throughout the next cycle (2-cycle read).
- cpu_rdata holds its value after writes and after non-accepted cycles.

RAM:
- Synchronous byte read and byte write.
- Read of the address written in the previous cycle returns the new data.

IO reads:
- 0x30000: cpu_rdata <= rx_data; rx_ready = 1 in the accepting cycle (combinational).
- 0x30004: cpu_rdata <= counter[7:0]; snapshot <= counter[31:8] in the same edge.
- 0x30005 / 0x30006 / 0x30007: return snapshot bytes [7:0] / [15:8] / [23:16].
- Any other IO address: 0x00.

IO writes:
- 0x30000 with nonzero data: push to tx FIFO. Data 0x00 is ignored (accepted, no push).
- 0x30004: set halted = 1 and push 0x00 to tx FIFO.
- Other IO addresses: accepted, no effect.

Cycle counter:
- 32-bit, increments every clock while halted = 0, wraps 0xFFFFFFFF -> 0.
- Frozen once halted.
- halted is sticky until reset; the bus keeps serving after halt.

tx FIFO:
- Pop on tx_valid && tx_ready.
- Push and pop in the same cycle is allowed when not full; count is unchanged.
- When full, the push stalls via rdy_out even if a pop occurs in the same cycle (no pass-through).
- Pointers wrap modulo TX_FIFO_DEPTH.

Reset mid-operation:
- A pending stalled request is dropped.
- A read in flight returns 0x00 (cpu_rdata reset).

Test Plan:
1. RAM write/read: write 0xA5 @0x01234; read 0x01234 in the next cycle -> cpu_rdata = 0xA5 one cycle after the read is accepted; rdy_out stays high throughout.
2. RAM aliasing: write 0x3C @0x21234 -> read @0x01234 returns 0x3C (bit 17 set, bits 17:16 != 11 -> RAM, bit 17 dropped).
3. UART tx with backpressure:
   - Hold tx_ready = 0 and issue 8 writes of 0x41..0x48 to 0x30000 -> all accepted.
   - The 9th write (0x49) sees rdy_out = 0.
   - Raise tx_ready -> tx_data emits 0x41 first; the 9th write is accepted the cycle after the first pop.
   - A write of 0x00 to 0x30000 produces no tx byte.
4. UART rx stall: read 0x30000 with rx_valid = 0 -> rdy_out = 0 for 5 cycles, rx_ready = 0. Assert rx_valid with rx_data = 0x7E -> rx_ready pulses 1 cycle, cpu_rdata = 0x7E the next cycle.
5. Clock counter:
   - After reset, read 0x30004 at the edge where counter = 0x00012345 -> 0x45.
   - Subsequent reads of 0x30005/6/7 -> 0x23, 0x01, 0x00, even though the counter has advanced.
6. Halt and reset:
   - Write 0x30004 -> halted = 1, 0x00 appears on tx_data, counter frozen.
   - Drop rst_in asynchronously mid-cycle -> halted, tx_valid and cpu_rdata go to 0 immediately, without waiting for a clock edge.
